// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback: FSM state encoding and bit-timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles per serial bit.
    function automatic int baud_ticks(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Clock cycles from a start-bit edge to the centre of that bit.
    function automatic int half_ticks(input int clk_hz, input int bit_rate);
        return baud_ticks(clk_hz, bit_rate) / 2;
    endfunction

    // Width of a counter that can hold 0..ticks.
    function automatic int cnt_width(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style receiver: synchronises rxd, rejects false starts, samples bit centres,
// and pulses rx_valid half a bit after the last stop bit ends.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rxd,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    rx_break
);

    localparam int TICKS = baud_ticks(CLK_HZ, BIT_RATE);
    localparam int HALF  = half_ticks(CLK_HZ, BIT_RATE);
    localparam int CW    = cnt_width(TICKS);
    localparam int IW    = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

    logic [1:0]              sync_reg;
    logic                    rxd_s;
    uart_state_t             state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [PAYLOAD_BITS-1:0] data_reg;
    logic                    valid_reg;
    logic                    break_reg;

    assign rxd_s    = sync_reg[1];
    assign rx_data  = data_reg;
    assign rx_valid = valid_reg;
    assign rx_break = break_reg;

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk) begin
        if (!resetn) sync_reg <= 2'b11;
        else         sync_reg <= {sync_reg[0], rxd};
    end

    // Receive FSM: start validation at half bit, then one sample per bit period.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            break_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            break_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                    if (!rxd_s) state_reg <= START;
                end
                START: begin
                    if (cnt_reg == CW'(HALF - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == CW'(TICKS - 1)) begin
                        cnt_reg  <= '0;
                        data_reg <= {rxd_s, data_reg[PAYLOAD_BITS-1:1]};
                        if (idx_reg == IW'(PAYLOAD_BITS - 1)) begin
                            idx_reg   <= '0;
                            state_reg <= STOP;
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    // Stop-bit value is not checked for acceptance; the extra
                    // period after the last stop centre delays the echo start.
                    if (cnt_reg == CW'(TICKS - 1)) begin
                        cnt_reg <= '0;
                        if (idx_reg == IW'(STOP_BITS)) begin
                            idx_reg   <= '0;
                            state_reg <= IDLE;
                            valid_reg <= 1'b1;
                            break_reg <= (data_reg == '0);
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, payload LSB first, STOP_BITS high bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_en,
    output logic                    txd,
    output logic                    tx_busy
);

    localparam int TICKS = baud_ticks(CLK_HZ, BIT_RATE);
    localparam int CW    = cnt_width(TICKS);
    localparam int IW    = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

    uart_state_t             state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic                    txd_reg;

    assign txd     = txd_reg;
    assign tx_busy = (state_reg != IDLE);

    // Transmit FSM; tx_en is ignored unless idle, so a byte arriving mid-frame is dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    txd_reg <= 1'b1;
                    cnt_reg <= '0;
                    idx_reg <= '0;
                    if (tx_en) begin
                        shift_reg <= tx_data;
                        txd_reg   <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == CW'(TICKS - 1)) begin
                        cnt_reg   <= '0;
                        txd_reg   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state_reg <= DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == CW'(TICKS - 1)) begin
                        cnt_reg <= '0;
                        if (idx_reg == IW'(PAYLOAD_BITS - 1)) begin
                            idx_reg   <= '0;
                            txd_reg   <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            idx_reg   <= idx_reg + IW'(1);
                            txd_reg   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_reg == CW'(TICKS - 1)) begin
                        cnt_reg <= '0;
                        if (idx_reg == IW'(STOP_BITS - 1)) begin
                            idx_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_top.sv
// UART loopback: every received byte is echoed on uart_txd and shown on led_out.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    output logic                    uart_txd,
    output logic [PAYLOAD_BITS-1:0] led_out
);

    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rx_valid;
    logic                    rx_break;
    logic                    tx_busy;
    logic                    tx_en;
    logic [PAYLOAD_BITS-1:0] led_reg;

    assign tx_en   = rx_valid & ~tx_busy;
    assign led_out = led_reg;

    uart_rx #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .STOP_BITS   (STOP_BITS)
    ) u_rx (
        .clk     (clk),
        .resetn  (resetn),
        .rxd     (uart_rxd),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_break(rx_break)
    );

    uart_tx #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .STOP_BITS   (STOP_BITS)
    ) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .tx_data(rx_data),
        .tx_en  (tx_en),
        .txd    (uart_txd),
        .tx_busy(tx_busy)
    );

    // Latch the most recent received byte for display.
    always_ff @(posedge clk) begin
        if (!resetn)       led_reg <= '0;
        else if (rx_valid) led_reg <= rx_data;
    end

endmodule

// File: tb/tb_uart_top.sv
// Loopback bench: drives 8N1 frames into uart_rxd, decodes uart_txd at bit centres
// and matches each echoed frame against a queue of sent bytes.
module tb_uart_top;

    localparam int CLK_HZ   = 153_600;
    localparam int BIT_RATE = 9600;
    localparam int PB       = 8;
    localparam int SB       = 1;
    localparam int T        = CLK_HZ / BIT_RATE;
    localparam int HALF     = T / 2;
    localparam int TIMEOUT  = 2 * (PB + SB + 2) * T;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          uart_txd;
    logic [PB-1:0] led_out;

    uart_top #(
        .CLK_HZ      (CLK_HZ),
        .BIT_RATE    (BIT_RATE),
        .PAYLOAD_BITS(PB),
        .STOP_BITS   (SB)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PB-1:0] data;
        logic [PB-1:0] led;
    } vec_t;

    vec_t          vecs [7];
    logic [PB-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_start_cnt = 0;
    int mon_cnt = 0;
    int break_cnt = 0;
    int valid_cyc = 0;
    int fall_cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe internal receive strobes for break counting and echo latency.
    always @(negedge clk) begin
        if (dut.rx_break) break_cnt <= break_cnt + 1;
        if (dut.rx_valid) valid_cyc <= cyc;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [PB-1:0] b);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < PB; i++) begin
            uart_rxd = b[i];
            repeat (T) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (T * SB) @(negedge clk);
    endtask

    // Transmit-side monitor: decode each echoed frame and score it.
    initial begin
        logic [PB-1:0] d;
        logic [PB-1:0] e;
        logic          start_bit;
        logic          stop_bit;
        wait (mon_en);
        forever begin
            @(negedge uart_txd);
            fall_cyc = cyc;
            tx_start_cnt++;
            repeat (HALF) @(negedge clk);
            start_bit = uart_txd;
            for (int i = 0; i < PB; i++) begin
                repeat (T) @(negedge clk);
                d[i] = uart_txd;
            end
            chk("echo_start_bit", int'(start_bit), 0);
            for (int s = 0; s < SB; s++) begin
                repeat (T) @(negedge clk);
                stop_bit = uart_txd;
                chk("echo_stop_bit", int'(stop_bit), 1);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_echo: got 0x%02h, expected no frame", d);
            end else begin
                e = exp_q.pop_front();
                $display("echo frame: got 0x%02h, expected 0x%02h", d, e);
                chk("echo_data", int'(d), int'(e));
            end
            mon_cnt++;
        end
    end

    task automatic do_byte(input logic [PB-1:0] b, input logic [PB-1:0] exp_led);
        int s0;
        int m0;
        int k;
        int lat;
        s0 = tx_start_cnt;
        m0 = mon_cnt;
        exp_q.push_back(b);
        send_byte(b);
        k = 0;
        while (tx_start_cnt == s0 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        chk("echo_start_timeout", int'(tx_start_cnt != s0), 1);
        if (tx_start_cnt == s0) begin
            void'(exp_q.pop_back());
            return;
        end
        lat = fall_cyc - valid_cyc;
        chk("echo_latency_le_2", int'(lat >= 0 && lat <= 2), 1);
        k = 0;
        while (mon_cnt == m0 && k < (PB + SB + 2) * T) begin
            @(negedge clk);
            k++;
        end
        chk("echo_frame_done", int'(mon_cnt != m0), 1);
        chk("led_out", int'(led_out), int'(exp_led));
        repeat (T / 4) @(negedge clk);
    endtask

    initial begin
        int s0;
        int bc;
        logic [PB-1:0] rb;

        vecs[0] = '{8'h41, 8'h41};
        vecs[1] = '{8'h5A, 8'h5A};
        vecs[2] = '{8'h30, 8'h30};
        vecs[3] = '{8'hFF, 8'hFF};
        vecs[4] = '{8'h01, 8'h01};
        vecs[5] = '{8'h55, 8'h55};
        vecs[6] = '{8'hAA, 8'hAA};

        // Reset state
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_txd", int'(uart_txd), 1);
        chk("reset_led", int'(led_out), 0);
        resetn = 1'b1;
        mon_en = 1'b1;
        repeat (2 * T) @(negedge clk);

        // Table of basic bytes
        for (int i = 0; i < 7; i++) do_byte(vecs[i].data, vecs[i].led);

        // Short low glitch must not start a frame
        s0 = tx_start_cnt;
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (T / 4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * T) @(negedge clk);
        chk("glitch_no_echo", tx_start_cnt - s0, 0);
        do_byte(8'hAA, 8'hAA);

        // All-zero byte: echoed normally, break flag pulses once
        bc = break_cnt;
        do_byte(8'h00, 8'h00);
        chk("rx_break_once", break_cnt - bc, 1);
        do_byte(8'h5A, 8'h5A);
        chk("rx_break_not_for_5a", break_cnt - bc, 1);

        // Random bytes followed by alternating patterns
        for (int i = 0; i < 20; i++) begin
            rb = PB'($urandom_range(0, 255));
            do_byte(rb, rb);
        end
        do_byte(8'h55, 8'h55);
        do_byte(8'hAA, 8'hAA);

        // Reset mid-frame: partial 0xDE is discarded, led cleared
        s0 = tx_start_cnt;
        fork
            send_byte(8'hDE);
            begin
                repeat (7 * T + HALF) @(negedge clk);
                resetn = 1'b0;
                repeat (2) @(negedge clk);
                resetn = 1'b1;
            end
        join
        chk("led_after_reset", int'(led_out), 0);
        repeat (3 * T) @(negedge clk);
        chk("no_echo_after_reset", tx_start_cnt - s0, 0);
        do_byte(8'hAD, 8'hAD);
        chk("only_ad_echoed", tx_start_cnt - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #4_000_000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "time limit");
    end

endmodule
